// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the custom-bus to APB master bridge.
package apb_bridge_pkg;

  // Bridge sequencing: accept a request, run the APB SETUP/ACCESS pair, then answer.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  // Read data returned for writes, window misses and aborted accesses.
  localparam int unsigned ERR_RDATA = 0;

endpackage

// File: rtl/apb_addr_decode.sv
// Address window check for one APB window: flags a hit and produces the
// window-relative offset. Comparison is unsigned and overflow-safe because
// the offset is formed first and compared against the span.
module apb_addr_decode #(
  parameter int unsigned           ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]     BASE_ADDR = '0,
  parameter logic [ADDR_W-1:0]     ADDR_SPAN = ADDR_W'('h100)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [ADDR_W-1:0] offset
);

  // Subtract the base, then hit only when the address is at/above base and the offset is inside the span.
  always_comb begin
    offset = addr - BASE_ADDR;
    hit    = (addr >= BASE_ADDR) && (offset < ADDR_SPAN);
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding bridge from the processor-side valid/ready bus to APB.
// Requests outside the window are answered with an error and no APB cycle.
// Optional feature macro: APB_BRIDGE_TIMEOUT_EN (abort ACCESS after
// TIMEOUT_CYCLES cycles without PREADY).
//
// Handshake: a request transfers on a rising edge where C_VALID and C_READY
// are both high; C_READY is high only in IDLE (and low during reset). The
// answer is a single-cycle C_RVALID pulse; C_RDATA/C_ERR are 0 outside it.
module apb_master_bridge
  import apb_bridge_pkg::*;
#(
  parameter int unsigned          BUS_WIDTH      = 32,
  parameter logic [BUS_WIDTH-1:0] BASE_ADDR      = '0,
  parameter logic [BUS_WIDTH-1:0] ADDR_SPAN      = BUS_WIDTH'('h100),
  parameter int unsigned          TIMEOUT_CYCLES = 64
) (
  input  logic                 S_CLK,
  input  logic                 S_RST,
  input  logic                 C_VALID,
  output logic                 C_READY,
  input  logic                 C_WRITE,
  input  logic [BUS_WIDTH-1:0] C_ADDR,
  input  logic [BUS_WIDTH-1:0] C_WDATA,
  output logic                 C_RVALID,
  output logic [BUS_WIDTH-1:0] C_RDATA,
  output logic                 C_ERR,
  output logic                 M_PSEL,
  output logic                 M_PENABLE,
  output logic                 M_PWRITE,
  output logic [BUS_WIDTH-1:0] M_PADDR,
  output logic [BUS_WIDTH-1:0] M_PWDATA,
  input  logic                 M_PREADY,
  input  logic                 M_PSLVERR,
  input  logic [BUS_WIDTH-1:0] M_PRDATA,
  output apb_state_e           DBG_STATE
);

  apb_state_e           state_q;
  apb_state_e           state_d;
  logic                 dec_hit;
  logic [BUS_WIDTH-1:0] dec_offset;
  logic                 xfer;
  logic                 apb_phase;
  logic                 access_done;
  logic                 timeout_hit;
  logic                 wr_q;
  logic [BUS_WIDTH-1:0] paddr_q;
  logic [BUS_WIDTH-1:0] pwdata_q;
  logic [BUS_WIDTH-1:0] rdata_q;
  logic                 err_q;

  apb_addr_decode #(
    .ADDR_W    (BUS_WIDTH),
    .BASE_ADDR (BASE_ADDR),
    .ADDR_SPAN (ADDR_SPAN)
  ) u_decode (
    .addr   (C_ADDR),
    .hit    (dec_hit),
    .offset (dec_offset)
  );

  assign xfer        = C_VALID && C_READY;
  assign apb_phase   = (state_q == SETUP) || (state_q == ACCESS);
  // PREADY only matters in ACCESS; stray PREADY from registered slaves is ignored elsewhere.
  assign access_done = (state_q == ACCESS) && M_PREADY;

`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;

  // Count ACCESS cycles without PREADY; cleared in SETUP so every access starts from zero.
  always_ff @(posedge S_CLK or posedge S_RST) begin
    if (S_RST) begin
      to_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      to_cnt_q <= '0;
    end else if ((state_q == ACCESS) && !M_PREADY) begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  // The limit is reached on the TIMEOUT_CYCLES-th waiting cycle; PREADY in that cycle wins.
  assign timeout_hit = (state_q == ACCESS) && !M_PREADY &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register; reset abandons any transaction immediately.
  always_ff @(posedge S_CLK or posedge S_RST) begin
    if (S_RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer) state_d = dec_hit ? SETUP : RESP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (access_done || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture in IDLE and response capture at the end of ACCESS.
  always_ff @(posedge S_CLK or posedge S_RST) begin
    if (S_RST) begin
      wr_q     <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else if ((state_q == IDLE) && xfer) begin
      wr_q     <= C_WRITE;
      paddr_q  <= dec_offset;
      pwdata_q <= C_WDATA;
      rdata_q  <= BUS_WIDTH'(ERR_RDATA);
      err_q    <= !dec_hit;
    end else if (access_done) begin
      rdata_q  <= wr_q ? BUS_WIDTH'(ERR_RDATA) : M_PRDATA;
      err_q    <= M_PSLVERR;
    end else if (timeout_hit) begin
      rdata_q  <= BUS_WIDTH'(ERR_RDATA);
      err_q    <= 1'b1;
    end
  end

  // Outputs decoded from state: APB fields only during SETUP/ACCESS, response only in RESP.
  always_comb begin
    C_READY   = (state_q == IDLE) && !S_RST;
    M_PSEL    = apb_phase;
    M_PENABLE = (state_q == ACCESS);
    M_PWRITE  = apb_phase && wr_q;
    M_PADDR   = apb_phase ? paddr_q  : '0;
    M_PWDATA  = apb_phase ? pwdata_q : '0;
    C_RVALID  = (state_q == RESP);
    C_RDATA   = (state_q == RESP) ? rdata_q : '0;
    C_ERR     = (state_q == RESP) && err_q;
    DBG_STATE = state_q;
  end

endmodule
